// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Byte address = word index << WORD_SHIFT
    localparam int unsigned WORD_SHIFT = 2;

    // Requester indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick; the caller owns the last_grant register.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid_c,
    output logic winner_c
);

    // On a tie the requester that did not win last time is chosen
    always_comb begin
        valid_c  = req0 | req1;
        winner_c = M0;
        if (req0 && req1) begin
            winner_c = (last_grant == M0) ? M1 : M0;
        end else if (req1) begin
            winner_c = M1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port data memory between two requesters.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [BURST_W-1:0] m0_len,
    input  logic [DATA_W-1:0]  m0_wdata,
    output logic               m0_gnt,
    output logic [DATA_W-1:0]  m0_rdata,
    output logic               m0_rvalid,
    output logic               m0_done,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [BURST_W-1:0] m1_len,
    input  logic [DATA_W-1:0]  m1_wdata,
    output logic               m1_gnt,
    output logic [DATA_W-1:0]  m1_rdata,
    output logic               m1_rvalid,
    output logic               m1_done,
    output logic [ADDR_W-1:0]  mem_access_addr,
    output logic [DATA_W-1:0]  mem_write_data,
    output logic               mem_write_en,
    output logic               mem_read_en,
    input  logic [DATA_W-1:0]  mem_read_data
);

    state_t             state;
    state_t             state_next;
    logic               owner;
    logic               last_grant;
    logic               we_q;
    logic [ADDR_W-1:0]  base_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] beat;
    logic               arb_valid;
    logic               arb_winner;
    logic               last_beat;

    rr_arb2 u_rr_arb2 (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant),
        .valid_c    (arb_valid),
        .winner_c   (arb_winner)
    );

    assign last_beat = (beat == len_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus grant and memory-port decode; all quiet outside BURST
    always_comb begin
        state_next      = state;
        m0_gnt          = 1'b0;
        m1_gnt          = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                mem_access_addr = base_q + (ADDR_W'(beat) << WORD_SHIFT);
                m0_gnt          = (owner == M0);
                m1_gnt          = (owner == M1);
                mem_write_en    = we_q;
                mem_read_en     = !we_q;
                if (we_q) begin
                    mem_write_data = (owner == M1) ? m1_wdata : m0_wdata;
                end
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch burst parameters at grant and step the beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= M0;
            last_grant <= M1;
            we_q       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            beat       <= '0;
        end else if (state == IDLE) begin
            if (arb_valid) begin
                owner      <= arb_winner;
                last_grant <= arb_winner;
                we_q       <= (arb_winner == M1) ? m1_we   : m0_we;
                base_q     <= (arb_winner == M1) ? m1_addr : m0_addr;
                len_q      <= (arb_winner == M1) ? m1_len  : m0_len;
                beat       <= '0;
            end
        end else begin
            beat <= beat + BURST_W'(1);
        end
    end

    // Registered read return and completion strobes for the owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            if (state == BURST) begin
                if (!we_q) begin
                    if (owner == M0) begin
                        m0_rvalid <= 1'b1;
                        m0_rdata  <= mem_read_data;
                    end else begin
                        m1_rvalid <= 1'b1;
                        m1_rdata  <= mem_read_data;
                    end
                end
                if (last_beat) begin
                    if (owner == M0) begin
                        m0_done <= 1'b1;
                    end else begin
                        m1_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a word-array memory and a shadow copy.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_done;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_len;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_done;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_len;
    logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read_en;

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];
    int          vectors;
    int          miscompares;

    data_mem_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_req          (m0_req),
        .m0_we           (m0_we),
        .m0_addr         (m0_addr),
        .m0_len          (m0_len),
        .m0_wdata        (m0_wdata),
        .m0_gnt          (m0_gnt),
        .m0_rdata        (m0_rdata),
        .m0_rvalid       (m0_rvalid),
        .m0_done         (m0_done),
        .m1_req          (m1_req),
        .m1_we           (m1_we),
        .m1_addr         (m1_addr),
        .m1_len          (m1_len),
        .m1_wdata        (m1_wdata),
        .m1_gnt          (m1_gnt),
        .m1_rdata        (m1_rdata),
        .m1_rvalid       (m1_rvalid),
        .m1_done         (m1_done),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_read_data   (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small word-indexed memory; upper address bits alias
    assign mem_read_data = mem[mem_access_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr[9:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input logic m);
        return m ? m1_gnt : m0_gnt;
    endfunction
    function automatic logic rvalid_of(input logic m);
        return m ? m1_rvalid : m0_rvalid;
    endfunction
    function automatic logic done_of(input logic m);
        return m ? m1_done : m0_done;
    endfunction
    function automatic logic [31:0] rdata_of(input logic m);
        return m ? m1_rdata : m0_rdata;
    endfunction

    task automatic set_req(input logic m, input logic r, input logic we,
                           input logic [31:0] a, input logic [3:0] len);
        if (m) begin
            m1_req = r; m1_we = we; m1_addr = a; m1_len = len;
        end else begin
            m0_req = r; m0_we = we; m0_addr = a; m0_len = len;
        end
    endtask

    task automatic set_wdata(input logic m, input logic [31:0] d);
        if (m) m1_wdata = d;
        else   m0_wdata = d;
    endtask

    task automatic check_quiet(input string tag, input bit with_rdata);
        check({tag, "_gnt"},    64'({m0_gnt, m1_gnt}), 64'd0);
        check({tag, "_rvalid"}, 64'({m0_rvalid, m1_rvalid}), 64'd0);
        check({tag, "_done"},   64'({m0_done, m1_done}), 64'd0);
        check({tag, "_mem_en"}, 64'({mem_write_en, mem_read_en}), 64'd0);
        check({tag, "_addr"},   64'(mem_access_addr), 64'd0);
        check({tag, "_wdata"},  64'(mem_write_data), 64'd0);
        if (with_rdata) begin
            check({tag, "_rdata0"}, 64'(m0_rdata), 64'd0);
            check({tag, "_rdata1"}, 64'(m1_rdata), 64'd0);
        end
    endtask

    // One burst by requester m with the other idle; entered and left #1 after a negedge
    task automatic burst(input logic m, input logic we, input logic [31:0] base,
                         input int len, input bit directed);
        logic [31:0] exp_q[$];
        logic [31:0] a;
        logic [31:0] wd;
        int          waited;
        wd = directed ? 32'hA0 : $urandom;
        set_req(m, 1'b1, we, base, 4'(len));
        set_wdata(m, wd);
        waited = 0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (gnt_of(m) !== 1'b1 && waited < 8);
        check("gnt_latency", 64'(waited), 64'd1);
        if (gnt_of(m) !== 1'b1) begin
            set_req(m, 1'b0, 1'b0, 32'h0, 4'h0);
            return;
        end
        for (int k = 0; k <= len; k++) begin
            if (k > 0) begin
                @(negedge clk);
                wd = directed ? 32'hA0 + 32'(k) : $urandom;
                set_wdata(m, wd);
                #1;
            end
            a = base + 32'(k) * 32'd4;
            check("beat_gnt_owner", 64'(gnt_of(m)), 64'd1);
            check("beat_gnt_other", 64'(gnt_of(~m)), 64'd0);
            check("beat_addr", 64'(mem_access_addr), 64'(a));
            check("beat_wen", 64'(mem_write_en), 64'(we));
            check("beat_ren", 64'(mem_read_en), 64'(!we));
            check("beat_done", 64'({done_of(m), done_of(~m)}), 64'd0);
            check("beat_rvalid_other", 64'(rvalid_of(~m)), 64'd0);
            if (we) begin
                check("beat_wdata", 64'(mem_write_data), 64'(wd));
                shadow[a[9:2]] = wd;
            end else begin
                exp_q.push_back(shadow[a[9:2]]);
            end
            if (!we && k > 0) begin
                check("beat_rvalid", 64'(rvalid_of(m)), 64'd1);
                check("beat_rdata", 64'(rdata_of(m)), 64'(exp_q[k-1]));
            end else begin
                check("beat_rvalid", 64'(rvalid_of(m)), 64'd0);
            end
            if (k == 0) begin
                // Drop req and scramble fields: the burst must be unaffected
                set_req(m, 1'b0, ~we, $urandom, 4'($urandom));
            end
        end
        @(negedge clk); #1;
        check("end_done", 64'(done_of(m)), 64'd1);
        check("end_done_other", 64'(done_of(~m)), 64'd0);
        check("end_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
        check("end_mem_en", 64'({mem_write_en, mem_read_en}), 64'd0);
        check("end_rvalid", 64'(rvalid_of(m)), 64'(!we));
        if (!we) check("end_rdata", 64'(rdata_of(m)), 64'(exp_q[len]));
        @(negedge clk); #1;
        check("post_done", 64'({m0_done, m1_done}), 64'd0);
        check("post_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        if (!we) check("post_rdata_hold", 64'(rdata_of(m)), 64'(exp_q[len]));
    endtask

    initial begin
        logic        mr;
        logic [31:0] base;
        int          len;
        int          starts, cur, beats, gap, cyc, who;
        logic        any, prev_any;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        m0_wdata = 32'h0;
        m1_wdata = 32'h0;
        #1;
        check_quiet("reset", 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_quiet("after_reset", 1'b1);

        // Directed write then read back
        burst(1'b0, 1'b1, 32'h40, 3, 1'b1);
        burst(1'b0, 1'b0, 32'h40, 3, 1'b0);

        // Address carry past the top of the space
        burst(1'b1, 1'b1, 32'hFFFF_FFFC, 1, 1'b0);
        burst(1'b1, 1'b0, 32'hFFFF_FFFC, 1, 1'b0);

        // Long write with req withdrawn after first beat, read by the other side
        burst(1'b1, 1'b1, 32'h80, 7, 1'b0);
        burst(1'b0, 1'b0, 32'h80, 7, 1'b0);

        // Random write/read pairs
        for (int i = 0; i < 6; i++) begin
            mr   = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(0, 3));
            base = 32'h100 + 32'($urandom_range(0, 60)) * 32'd4;
            burst(mr, 1'b1, base, len, 1'b0);
            burst(~mr, 1'b0, base, len, 1'b0);
        end

        // Asynchronous reset in the middle of a write burst
        set_req(1'b0, 1'b1, 1'b1, 32'h180, 4'd5);
        m0_wdata = $urandom;
        @(negedge clk); #1;
        check("rst_beat0_gnt", 64'(m0_gnt), 64'd1);
        m0_req = 1'b0;
        @(negedge clk); m0_wdata = $urandom; #1;
        @(negedge clk); m0_wdata = $urandom; #1;
        check("rst_beat2_wen", 64'(mem_write_en), 64'd1);
        check("rst_beat2_addr", 64'(mem_access_addr), 64'h188);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("rst_async", 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_quiet("rst_held", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_quiet("rst_release", 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_quiet("rst_no_done", 1'b1);
        end

        // Both requesters held: strict alternation starting with m0, one bubble between bursts
        set_req(1'b0, 1'b1, 1'b1, 32'h200, 4'd1);
        set_req(1'b1, 1'b1, 1'b1, 32'h300, 4'd2);
        starts = 0; cur = -1; beats = 0; gap = 0; cyc = 0; prev_any = 1'b0;
        while ((starts < 6 || cur >= 0) && cyc < 200) begin
            @(negedge clk);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            #1;
            cyc++;
            any = m0_gnt | m1_gnt;
            check("fair_overlap", 64'(m0_gnt & m1_gnt), 64'd0);
            if (any && !prev_any) begin
                who = m1_gnt ? 1 : 0;
                check("fair_order", 64'(who), 64'(starts % 2));
                if (starts > 0) check("fair_bubble", 64'(gap), 64'd1);
                starts++;
                cur = who;
                beats = 1;
                if (starts == 6) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end else if (any) begin
                check("fair_owner_stable", 64'(m1_gnt ? 1 : 0), 64'(cur));
                beats++;
            end else if (prev_any) begin
                check("fair_beats", 64'(beats), 64'(cur == 1 ? 3 : 2));
                check("fair_done", 64'(cur == 1 ? m1_done : m0_done), 64'd1);
                cur = -1;
                gap = 1;
            end else begin
                gap++;
            end
            if (any) check("fair_wdata", 64'(mem_write_data), 64'(m1_gnt ? m1_wdata : m0_wdata));
            prev_any = any;
        end
        check("fair_bursts", 64'(starts), 64'd6);
        check("fair_complete", 64'(cur + 1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
